// File: rtl/slsu.sv
// Single-outstanding load/store unit: checks a request, performs one memory
// access, and holds the response until the consumer takes it.
module slsu #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic [4:0]            resp_rd_o,
  output logic                  resp_err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [1:0]            mem_size_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Highest address at which a full word still fits; applies to every size.
  localparam logic [DATA_WIDTH-1:0] LAST_WORD = DATA_WIDTH'(MEM_SIZE - 4);

  state_t                state;
  state_t                state_next;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            rd_q;

  logic                  accept;
  logic                  funct3_ok;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] load_ext;

  assign req_ready_o  = rst_n && (state == IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = (state == RESP);

  always_comb begin
    funct3_ok = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !req_we_i;
      default:                funct3_ok = 1'b0;
    endcase
  end

  assign misaligned   = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign out_of_range = req_addr_i > LAST_WORD;
  assign req_err      = !funct3_ok || misaligned || out_of_range;

  // Memory returns the addressed bytes in the low lanes; only re-extension is needed.
  always_comb begin
    load_ext = mem_rdata_i;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){mem_rdata_i[7]}}, mem_rdata_i[7:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, mem_rdata_i[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, mem_rdata_i[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Strobes are gated by rst_n so a reset mid-access never reaches memory.
  assign mem_read_o  = rst_n && (state == ACCESS) && !we_q;
  assign mem_write_o = rst_n && (state == ACCESS) && we_q;
  assign mem_size_o  = funct3_q[1:0];
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 5'd0;
      resp_rdata_o <= '0;
      resp_rd_o    <= 5'd0;
      resp_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        rd_q     <= req_rd_i;
        if (req_err) begin
          resp_err_o   <= 1'b1;
          resp_rdata_o <= '0;
          resp_rd_o    <= req_rd_i;
        end
      end
      if (state == ACCESS) begin
        resp_err_o   <= 1'b0;
        resp_rdata_o <= we_q ? '0 : load_ext;
        resp_rd_o    <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_slsu.sv
// Scoreboard bench for slsu: directed loads/stores against a byte-array memory
// model, with a separate monitor popping expected responses.
module tb_slsu;

  localparam int DW = 32;
  localparam int MS = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [4:0]    req_rd;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [4:0]    resp_rd;
  logic          resp_err;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_size;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   write_cycles = 0;
  int   read_cycles  = 0;

  logic [7:0] mem [0:MS-1] = '{default: 8'h00};

  always #5 clk = ~clk;

  slsu #(.DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_rd_i(req_rd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_rd_o(resp_rd), .resp_err_o(resp_err),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_size_o(mem_size),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Little-endian byte memory; reads return the addressed bytes in the low lanes.
  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'(MS - 4))
      mem_rdata = {mem[int'(mem_addr[9:0]) + 3], mem[int'(mem_addr[9:0]) + 2],
                   mem[int'(mem_addr[9:0]) + 1], mem[int'(mem_addr[9:0])]};
  end

  always @(posedge clk) begin
    if (mem_write && mem_addr <= 32'(MS - 4)) begin
      mem[int'(mem_addr[9:0])] = mem_wdata[7:0];
      if (mem_size != 2'b00) mem[int'(mem_addr[9:0]) + 1] = mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        mem[int'(mem_addr[9:0]) + 2] = mem_wdata[23:16];
        mem[int'(mem_addr[9:0]) + 3] = mem_wdata[31:24];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every completed response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_write) write_cycles++;
    if (mem_read)  read_cycles++;
    if (rst_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_rd", 32'(resp_rd), 32'(e.rd));
        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic [31:0] exp_rdata,
                               input logic exp_err, input int hold);
    exp_t e;
    int   lat;
    int   n;
    int   wr0;
    int   rd0;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
    resp_ready = (hold == 0);
    wr0 = write_cycles;
    rd0 = read_cycles;
    e.rdata = exp_rdata;
    e.rd    = rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    lat = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      if (mem_read || mem_write) begin
        checkOutput("mem_addr", mem_addr, addr);
        checkOutput("mem_size", 32'(mem_size), 32'(f3[1:0]));
        if (we) checkOutput("mem_wdata", mem_wdata, wdata);
      end
      @(posedge clk);
      lat++;
      n++;
    end
    checkOutput("latency", 32'(lat), exp_err ? 32'd1 : 32'd2);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_valid", 32'(resp_valid), 32'd1);
        checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
        checkOutput("stall_rdata", resp_rdata, exp_rdata);
        checkOutput("stall_rd", 32'(resp_rd), 32'(rd));
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_resp", 32'(req_ready), 32'd1);
    checkOutput("write_strobes", 32'(write_cycles - wr0), 32'(we && !exp_err));
    checkOutput("read_strobes", 32'(read_cycles - rd0), 32'(!we && !exp_err));
  endtask

  initial begin
    int wr0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    req_rd     = 5'd0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

    //            we    f3      addr       wdata          rd     expected       err  hold
    applyStimulus(1'b1, 3'b010, 32'h10,    32'h12345678, 5'd1,  32'h00000000, 1'b0, 0);
    applyStimulus(1'b0, 3'b010, 32'h10,    32'h0,        5'd2,  32'h12345678, 1'b0, 0);
    applyStimulus(1'b1, 3'b000, 32'h20,    32'h000000F0, 5'd3,  32'h00000000, 1'b0, 0);
    applyStimulus(1'b0, 3'b000, 32'h20,    32'h0,        5'd4,  32'hFFFFFFF0, 1'b0, 0);
    applyStimulus(1'b0, 3'b100, 32'h20,    32'h0,        5'd5,  32'h000000F0, 1'b0, 0);
    applyStimulus(1'b1, 3'b001, 32'h22,    32'h00008001, 5'd6,  32'h00000000, 1'b0, 0);
    applyStimulus(1'b0, 3'b101, 32'h22,    32'h0,        5'd7,  32'h00008001, 1'b0, 0);
    applyStimulus(1'b0, 3'b001, 32'h22,    32'h0,        5'd8,  32'hFFFF8001, 1'b0, 0);
    applyStimulus(1'b0, 3'b010, 32'h20,    32'h0,        5'd9,  32'h800100F0, 1'b0, 0);
    applyStimulus(1'b0, 3'b010, 32'h13,    32'h0,        5'd10, 32'h00000000, 1'b1, 0);
    applyStimulus(1'b1, 3'b001, 32'h21,    32'hAAAA5555, 5'd11, 32'h00000000, 1'b1, 0);
    applyStimulus(1'b0, 3'b010, 32'h3FE,   32'h0,        5'd12, 32'h00000000, 1'b1, 0);
    applyStimulus(1'b0, 3'b011, 32'h10,    32'h0,        5'd13, 32'h00000000, 1'b1, 0);
    applyStimulus(1'b1, 3'b100, 32'h10,    32'h0,        5'd14, 32'h00000000, 1'b1, 0);
    applyStimulus(1'b0, 3'b000, 32'h3FD,   32'h0,        5'd15, 32'h00000000, 1'b1, 0);
    applyStimulus(1'b0, 3'b010, 32'h3FC,   32'h0,        5'd16, 32'h00000000, 1'b0, 0);
    applyStimulus(1'b0, 3'b010, 32'h10,    32'h0,        5'd17, 32'h12345678, 1'b0, 5);
    applyStimulus(1'b1, 3'b010, 32'h30,    32'h11223344, 5'd18, 32'h00000000, 1'b0, 0);
    applyStimulus(1'b0, 3'b010, 32'h30,    32'h0,        5'd19, 32'h11223344, 1'b0, 0);

    // Reset lands in the ACCESS cycle of a store: nothing may reach memory.
    @(posedge clk); #1;
    wr0 = write_cycles;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    req_wdata  = 32'hDEADBEEF;
    req_rd     = 5'd20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    checkOutput("abort_write_gated", 32'(mem_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort_resp_rdata", resp_rdata, 32'd0);
    checkOutput("abort_resp_rd", 32'(resp_rd), 32'd0);
    checkOutput("abort_resp_err", 32'(resp_err), 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready_after", 32'(req_ready), 32'd1);
    checkOutput("abort_no_write", 32'(write_cycles - wr0), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 5'd21, 32'h11223344, 1'b0, 0);

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
